// File: rtl/vz_loader_if.sv
// vz_loader_if: groups the ioctl download stream, the downstream write port
// and the load status flags used by vz_loader.
//   master : host/download side (drives ioctl_*, mem_busy; observes the rest)
//   slave  : vz_loader (consumes ioctl_*, mem_busy; drives wait, dn_*, status)
interface vz_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        mem_busy;
  logic        dn_wr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic [7:0]  dn_index;
  logic [7:0]  file_type;
  logic [15:0] exec_addr;
  logic        load_done;
  logic        load_err;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_busy,
    input  ioctl_wait, dn_wr, dn_addr, dn_data, dn_index, file_type, exec_addr,
           load_done, load_err
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_busy,
    output ioctl_wait, dn_wr, dn_addr, dn_data, dn_index, file_type, exec_addr,
           load_done, load_err
  );
endinterface

// File: rtl/vz_loader.sv
// vz_loader: sits between the ioctl download stream and the LASER310 download
// port. Index 0 (BIOS) passes straight through using ioctl_addr; any other
// index is parsed as a VZ snapshot: the header is checked and stripped and the
// payload is written from the start address found in the header. A one-entry
// output buffer applies ioctl_wait back-pressure while mem_busy is high.
//
// Ports:
//   clk_sys : single clock
//   reset   : synchronous, active-high
//   bus     : vz_loader_if.slave (ioctl stream in, dn_* write port out,
//             dn_index/file_type/exec_addr/load_done/load_err status)
//
// Build option:
//   VZ_BASIC_PATCH_EN - when defined, BASIC (F0) files get the BASIC
//   end-of-program pointer written with the address after the payload.
module vz_loader #(
  parameter int unsigned HDR_LEN       = 24,
  parameter logic [15:0] BASIC_END_PTR = 16'h78F9
) (
  input logic        clk_sys,
  input logic        reset,
  vz_loader_if.slave bus
);
  localparam int unsigned CW         = 16;
  localparam logic [CW-1:0] NAME_LAST = CW'(HDR_LEN - 4);
  localparam logic [7:0] TYPE_BASIC  = 8'hF0;

  typedef enum logic [3:0] {
    S_IDLE, S_PASS, S_MAGIC, S_NAME, S_TYPE, S_ADDR_LO, S_ADDR_HI,
    S_DATA, S_PATCH_LO, S_PATCH_HI, S_DONE, S_ERR
  } state_t;

  state_t      state_q;
  logic        dl_q;
  logic [CW-1:0] cnt_q;
  logic [15:0] wp_q;
  logic        buf_valid_q;
  logic [15:0] buf_addr_q;
  logic [7:0]  buf_data_q;
  logic [7:0]  index_q;
  logic [7:0]  type_q;
  logic [15:0] exec_q;
  logic        done_q;
  logic        err_q;

  logic       rise_c;
  logic       fall_c;
  logic       free_c;
  logic       accept_c;
  logic       hdr_c;
  logic       magic_bad_c;
  logic [7:0] magic_c;
  logic       unused_addr_c;

  assign rise_c = bus.ioctl_download & ~dl_q;
  assign fall_c = ~bus.ioctl_download & dl_q;

  // The held entry is released in the first cycle mem_busy is low, so these
  // two are decoded from the entry and live mem_busy rather than registered.
  assign bus.dn_wr      = buf_valid_q & ~bus.mem_busy & ~reset & ~rise_c;
  assign bus.ioctl_wait = buf_valid_q &  bus.mem_busy & ~reset & ~rise_c;

  // Buffer can take a new entry if empty or draining this cycle.
  assign free_c   = ~buf_valid_q | bus.dn_wr;
  assign accept_c = bus.ioctl_wr & ~bus.ioctl_wait;
  assign hdr_c    = (state_q == S_MAGIC) || (state_q == S_NAME) || (state_q == S_TYPE) ||
                    (state_q == S_ADDR_LO) || (state_q == S_ADDR_HI);

  assign bus.dn_addr   = buf_addr_q;
  assign bus.dn_data   = buf_data_q;
  assign bus.dn_index  = index_q;
  assign bus.file_type = type_q;
  assign bus.exec_addr = exec_q;
  assign bus.load_done = done_q;
  assign bus.load_err  = err_q;

  assign unused_addr_c = ^bus.ioctl_addr[24:16];

`ifndef VZ_BASIC_PATCH_EN
  logic unused_ptr_c;
  assign unused_ptr_c = ^BASIC_END_PTR;
`endif

  // Expected "VZF" byte for the current magic position (byte 3 unchecked).
  always_comb begin
    magic_c = 8'h00;
    case (cnt_q[1:0])
      2'd0:    magic_c = 8'h56;
      2'd1:    magic_c = 8'h5A;
      2'd2:    magic_c = 8'h46;
      default: magic_c = 8'h00;
    endcase
  end

  assign magic_bad_c = (cnt_q < CW'(3)) && (bus.ioctl_dout != magic_c);

  // Loader state machine, output buffer and status registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dl_q        <= 1'b0;
      cnt_q       <= '0;
      wp_q        <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      index_q     <= '0;
      type_q      <= '0;
      exec_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      dl_q <= bus.ioctl_download;
      if (bus.dn_wr) buf_valid_q <= 1'b0;

      if (rise_c) begin
        // New download from any state; a held byte is discarded.
        index_q     <= bus.ioctl_index;
        done_q      <= 1'b0;
        err_q       <= 1'b0;
        cnt_q       <= '0;
        buf_valid_q <= 1'b0;
        state_q     <= (bus.ioctl_index == 8'd0) ? S_PASS : S_MAGIC;
      end else begin
        if (bus.ioctl_wr && bus.ioctl_wait) err_q <= 1'b1;

        if (hdr_c && fall_c) begin
          // Download ended inside the header: truncated file.
          state_q <= S_ERR;
          err_q   <= 1'b1;
        end else begin
          case (state_q)
            S_IDLE: ;
            S_PASS: begin
              if (fall_c) begin
                state_q <= S_DONE;
              end else if (accept_c) begin
                buf_valid_q <= 1'b1;
                buf_addr_q  <= bus.ioctl_addr[15:0];
                buf_data_q  <= bus.ioctl_dout;
              end
            end
            S_MAGIC: begin
              if (accept_c) begin
                cnt_q <= cnt_q + CW'(1);
                if (magic_bad_c) begin
                  state_q <= S_ERR;
                  err_q   <= 1'b1;
                end else if (cnt_q == CW'(3)) begin
                  state_q <= S_NAME;
                end
              end
            end
            S_NAME: begin
              if (accept_c) begin
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == NAME_LAST) state_q <= S_TYPE;
              end
            end
            S_TYPE: begin
              if (accept_c) begin
                cnt_q   <= cnt_q + CW'(1);
                type_q  <= bus.ioctl_dout;
                state_q <= S_ADDR_LO;
              end
            end
            S_ADDR_LO: begin
              if (accept_c) begin
                cnt_q       <= cnt_q + CW'(1);
                exec_q[7:0] <= bus.ioctl_dout;
                state_q     <= S_ADDR_HI;
              end
            end
            S_ADDR_HI: begin
              if (accept_c) begin
                cnt_q        <= cnt_q + CW'(1);
                exec_q[15:8] <= bus.ioctl_dout;
                wp_q         <= {bus.ioctl_dout, exec_q[7:0]};
                state_q      <= S_DATA;
              end
            end
            S_DATA: begin
              if (fall_c) begin
`ifdef VZ_BASIC_PATCH_EN
                state_q <= (type_q == TYPE_BASIC) ? S_PATCH_LO : S_DONE;
`else
                state_q <= S_DONE;
`endif
              end else if (accept_c) begin
                buf_valid_q <= 1'b1;
                buf_addr_q  <= wp_q;
                buf_data_q  <= bus.ioctl_dout;
                wp_q        <= wp_q + 16'd1;
              end
            end
`ifdef VZ_BASIC_PATCH_EN
            // wp now points one past the payload: store it as the BASIC end.
            S_PATCH_LO: begin
              if (free_c) begin
                buf_valid_q <= 1'b1;
                buf_addr_q  <= BASIC_END_PTR;
                buf_data_q  <= wp_q[7:0];
                state_q     <= S_PATCH_HI;
              end
            end
            S_PATCH_HI: begin
              if (free_c) begin
                buf_valid_q <= 1'b1;
                buf_addr_q  <= BASIC_END_PTR + 16'd1;
                buf_data_q  <= wp_q[15:8];
                state_q     <= S_DONE;
              end
            end
`endif
            S_DONE: begin
              // Flush any pending write before flagging completion.
              if (free_c) begin
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end
            end
            S_ERR: begin
              err_q <= 1'b1;
              if (!bus.ioctl_download) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end
    end
  end

  logic unused_type_c;
  assign unused_type_c = ^TYPE_BASIC;
endmodule

// File: tb/tb_vz_loader.sv
module tb_vz_loader;
`ifdef VZ_BASIC_PATCH_EN
  localparam bit PATCH = 1'b1;
`else
  localparam bit PATCH = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    int          c;
  } wr_t;

  logic clk_sys = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  wr_t        got_q[$];
  logic [23:0] exp_q[$];
  logic [7:0]  file_q[$];
  int          wr_cyc_q[$];
  bit          exp_err;
  bit          exp_done;

  always #5 clk_sys = ~clk_sys;

  vz_loader_if bus();

  vz_loader dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Record every downstream write with the cycle it happened in.
  always @(negedge clk_sys) begin
    wr_t w;
    if (bus.dn_wr === 1'b1) begin
      w.a = bus.dn_addr;
      w.d = bus.dn_data;
      w.c = cyc;
      got_q.push_back(w);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: expected writes and status from the whole file.
  task automatic model(input logic [7:0] idx);
    logic [15:0] p;
    exp_q.delete();
    exp_err  = 1'b0;
    exp_done = 1'b0;
    if (idx == 8'd0) begin
      foreach (file_q[i]) exp_q.push_back({16'(i), file_q[i]});
      exp_done = 1'b1;
    end else if (file_q.size() < 24 || file_q[0] != 8'h56 || file_q[1] != 8'h5A ||
                 file_q[2] != 8'h46) begin
      exp_err = 1'b1;
    end else begin
      p = {file_q[23], file_q[22]};
      for (int i = 24; i < file_q.size(); i++) begin
        exp_q.push_back({p, file_q[i]});
        p = p + 16'd1;
      end
      if (PATCH && file_q[21] == 8'hF0) begin
        exp_q.push_back({16'h78F9, p[7:0]});
        exp_q.push_back({16'h78FA, p[15:8]});
      end
      exp_done = 1'b1;
    end
  endtask

  task automatic build_file(input logic [7:0] ft, input logic [15:0] st, input int n,
                            input bit badm);
    file_q.delete();
    file_q.push_back(8'h56);
    file_q.push_back(8'h5A);
    file_q.push_back(badm ? 8'h58 : 8'h46);
    file_q.push_back(8'h30);
    for (int i = 0; i < 17; i++) file_q.push_back(8'($urandom_range(0, 255)));
    file_q.push_back(ft);
    file_q.push_back(st[7:0]);
    file_q.push_back(st[15:8]);
    for (int i = 0; i < n; i++) file_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(posedge clk_sys); #1;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
  endtask

  // Present one byte, honouring ioctl_wait like the real ioctl source.
  task automatic put_byte(input logic [24:0] a, input logic [7:0] d, input int busy_pct);
    bit sent;
    sent = 1'b0;
    for (int g = 0; g < 200 && !sent; g++) begin
      bus.mem_busy = ($urandom_range(0, 99) < busy_pct);
      #1;
      if (bus.ioctl_wait !== 1'b1) begin
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        wr_cyc_q.push_back(cyc);
        sent = 1'b1;
      end
      @(posedge clk_sys); #1;
      bus.ioctl_wr = 1'b0;
    end
    total++;
    if (!sent) begin
      $display("FAIL put_byte_timeout: got wait stuck want wait released");
      bad++;
    end
  endtask

  task automatic end_dl(input int busy_pct);
    bus.ioctl_download = 1'b0;
    for (int k = 0; k < 25; k++) begin
      bus.mem_busy = ($urandom_range(0, 99) < busy_pct);
      @(posedge clk_sys); #1;
    end
    bus.mem_busy = 1'b0;
    repeat (10) begin @(posedge clk_sys); #1; end
  endtask

  task automatic send_file(input logic [7:0] idx, input int busy_pct);
    got_q.delete();
    wr_cyc_q.delete();
    start_dl(idx);
    foreach (file_q[i]) put_byte(25'(i), file_q[i], busy_pct);
    end_dl(busy_pct);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ioctl_download = 1'b0; bus.ioctl_index = '0; bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0; bus.ioctl_dout = '0; bus.mem_busy = 1'b0;
    repeat (3) begin @(posedge clk_sys); #1; end
    total++;
    if ({bus.dn_wr, bus.ioctl_wait} !== 2'b00) begin
      $display("FAIL reset_handshake: got %b want 00", {bus.dn_wr, bus.ioctl_wait}); bad++;
    end
    total++;
    if ({bus.dn_addr, bus.dn_data, bus.dn_index, bus.file_type, bus.exec_addr,
         bus.load_done, bus.load_err} !== 58'd0) begin
      $display("FAIL reset_status: got %h want 0", {bus.dn_addr, bus.dn_data, bus.dn_index,
               bus.file_type, bus.exec_addr, bus.load_done, bus.load_err}); bad++;
    end
    reset = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  task automatic test_pass();
    file_q.delete();
    for (int i = 0; i < 4; i++) file_q.push_back(8'($urandom_range(0, 255)));
    model(8'd0);
    send_file(8'd0, 0);
    total++;
    if (got_q.size() != 4) begin
      $display("FAIL pass_count: got %0d want 4", got_q.size()); bad++;
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      total++;
      if ({got_q[i].a, got_q[i].d} !== exp_q[i]) begin
        $display("FAIL pass_write%0d: got %h want %h", i, {got_q[i].a, got_q[i].d}, exp_q[i]); bad++;
      end
      total++;
      if (got_q[i].c != wr_cyc_q[i] + 1) begin
        $display("FAIL pass_latency%0d: got cycle %0d want %0d", i, got_q[i].c, wr_cyc_q[i] + 1); bad++;
      end
    end
    total++;
    if ({bus.load_done, bus.load_err} !== 2'b10) begin
      $display("FAIL pass_status: got %b want 10", {bus.load_done, bus.load_err}); bad++;
    end
  endtask

  task automatic test_vz(input logic [7:0] ft);
    build_file(ft, 16'h7A00, 0, 1'b0);
    file_q.push_back(8'hAA);
    file_q.push_back(8'hBB);
    model(8'd1);
    send_file(8'd1, 0);
    total++;
    if (got_q.size() != exp_q.size()) begin
      $display("FAIL vz_%h_count: got %0d want %0d", ft, got_q.size(), exp_q.size()); bad++;
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if ({got_q[i].a, got_q[i].d} !== exp_q[i]) begin
        $display("FAIL vz_%h_write%0d: got %h want %h", ft, i, {got_q[i].a, got_q[i].d}, exp_q[i]); bad++;
      end
    end
    total++;
    if ({bus.exec_addr, bus.file_type} !== {16'h7A00, ft}) begin
      $display("FAIL vz_%h_header: got %h want %h", ft, {bus.exec_addr, bus.file_type}, {16'h7A00, ft}); bad++;
    end
    total++;
    if ({bus.load_done, bus.load_err} !== 2'b10) begin
      $display("FAIL vz_%h_status: got %b want 10", ft, {bus.load_done, bus.load_err}); bad++;
    end
  endtask

  task automatic test_bad_header(input bit truncate);
    build_file(8'hF1, 16'h8000, 3, !truncate);
    if (truncate) while (file_q.size() > 10) void'(file_q.pop_back());
    send_file(8'd2, 0);
    total++;
    if (got_q.size() != 0) begin
      $display("FAIL bad_header%0d_writes: got %0d want 0", truncate, got_q.size()); bad++;
    end
    total++;
    if ({bus.load_done, bus.load_err} !== 2'b01) begin
      $display("FAIL bad_header%0d_status: got %b want 01", truncate, {bus.load_done, bus.load_err}); bad++;
    end
  endtask

  task automatic test_wait_overrun();
    int wcnt;
    int a;
    build_file(8'hF1, 16'h7A00, 0, 1'b0);
    got_q.delete();
    start_dl(8'd1);
    foreach (file_q[i]) put_byte(25'(i), file_q[i], 0);
    bus.mem_busy = 1'b0; bus.ioctl_wr = 1'b1; bus.ioctl_dout = 8'h11; a = cyc;
    @(posedge clk_sys); #1;
    bus.ioctl_wr = 1'b0;
    wcnt = 0;
    for (int k = 0; k < 3; k++) begin
      bus.mem_busy = 1'b1;
      if (k == 1) begin bus.ioctl_wr = 1'b1; bus.ioctl_dout = 8'h22; end
      #1;
      if (bus.ioctl_wait === 1'b1) wcnt++;
      @(posedge clk_sys); #1;
      bus.ioctl_wr = 1'b0;
    end
    bus.mem_busy = 1'b0;
    #1;
    total++;
    if ({bus.ioctl_wait, bus.dn_wr} !== 2'b01) begin
      $display("FAIL wait_release: got %b want 01", {bus.ioctl_wait, bus.dn_wr}); bad++;
    end
    @(posedge clk_sys); #1;
    total++;
    if (wcnt != 3) begin
      $display("FAIL wait_cycles: got %0d want 3", wcnt); bad++;
    end
    put_byte(25'd0, 8'h33, 0);
    end_dl(0);
    total++;
    if (got_q.size() != 2) begin
      $display("FAIL overrun_count: got %0d want 2", got_q.size()); bad++;
    end else begin
      total++;
      if ({got_q[0].a, got_q[0].d, got_q[1].a, got_q[1].d} !== 48'h7A00_11_7A01_33) begin
        $display("FAIL overrun_writes: got %h want 7a00117a0133",
                 {got_q[0].a, got_q[0].d, got_q[1].a, got_q[1].d}); bad++;
      end
      total++;
      if (got_q[0].c != a + 4) begin
        $display("FAIL overrun_wr_cycle: got %0d want %0d", got_q[0].c, a + 4); bad++;
      end
    end
    total++;
    if ({bus.load_done, bus.load_err} !== 2'b11) begin
      $display("FAIL overrun_status: got %b want 11", {bus.load_done, bus.load_err}); bad++;
    end
  endtask

  task automatic test_wrap();
    build_file(8'hF1, 16'hFFFF, 2, 1'b0);
    model(8'd3);
    send_file(8'd3, 0);
    total++;
    if (got_q.size() != 2) begin
      $display("FAIL wrap_count: got %0d want 2", got_q.size()); bad++;
    end else begin
      total++;
      if ({got_q[0].a, got_q[1].a} !== 32'hFFFF_0000) begin
        $display("FAIL wrap_addr: got %h want ffff0000", {got_q[0].a, got_q[1].a}); bad++;
      end
      total++;
      if ({got_q[0].d, got_q[1].d} !== {file_q[24], file_q[25]}) begin
        $display("FAIL wrap_data: got %h want %h", {got_q[0].d, got_q[1].d}, {file_q[24], file_q[25]}); bad++;
      end
    end
    total++;
    if ({bus.load_done, bus.load_err} !== 2'b10) begin
      $display("FAIL wrap_status: got %b want 10", {bus.load_done, bus.load_err}); bad++;
    end
  endtask

  task automatic test_reset_mid();
    got_q.delete();
    start_dl(8'd0);
    bus.mem_busy = 1'b0; bus.ioctl_wr = 1'b1; bus.ioctl_addr = '0; bus.ioctl_dout = 8'h5A;
    @(posedge clk_sys); #1;
    bus.ioctl_wr = 1'b0; bus.mem_busy = 1'b1;
    #1;
    total++;
    if (bus.ioctl_wait !== 1'b1) begin
      $display("FAIL reset_mid_held: got %b want 1", bus.ioctl_wait); bad++;
    end
    @(posedge clk_sys); #1;
    reset = 1'b1; bus.mem_busy = 1'b0; bus.ioctl_download = 1'b0;
    #1;
    total++;
    if (bus.dn_wr !== 1'b0) begin
      $display("FAIL reset_mid_dn_wr: got %b want 0", bus.dn_wr); bad++;
    end
    @(posedge clk_sys); #1;
    reset = 1'b0;
    repeat (5) begin @(posedge clk_sys); #1; end
    total++;
    if (got_q.size() != 0 || bus.ioctl_wait !== 1'b0) begin
      $display("FAIL reset_mid_abandon: got %0d writes wait %b want 0 writes wait 0",
               got_q.size(), bus.ioctl_wait); bad++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] idx;
    int n;
    for (int it = 0; it < 20; it++) begin
      idx = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (idx == 8'd0) begin
        file_q.delete();
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) file_q.push_back(8'($urandom_range(0, 255)));
      end else begin
        build_file(($urandom_range(0, 1) == 1) ? 8'hF0 : 8'hF1, 16'($urandom_range(0, 65535)),
                   $urandom_range(0, 6), ($urandom_range(0, 5) == 0));
        if ($urandom_range(0, 7) == 0)
          while (file_q.size() > 24 - $urandom_range(1, 20)) void'(file_q.pop_back());
      end
      model(idx);
      send_file(idx, 30);
      total++;
      if (got_q.size() != exp_q.size()) begin
        $display("FAIL b2b%0d_count: got %0d want %0d", it, got_q.size(), exp_q.size()); bad++;
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        total++;
        if ({got_q[i].a, got_q[i].d} !== exp_q[i]) begin
          $display("FAIL b2b%0d_write%0d: got %h want %h", it, i, {got_q[i].a, got_q[i].d}, exp_q[i]); bad++;
        end
      end
      total++;
      if ({bus.load_done, bus.load_err, bus.dn_index} !== {exp_done, exp_err, idx}) begin
        $display("FAIL b2b%0d_status: got %h want %h", it, {bus.load_done, bus.load_err, bus.dn_index},
                 {exp_done, exp_err, idx}); bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_vz(8'hF1);
    test_vz(8'hF0);
    test_bad_header(1'b0);
    test_bad_header(1'b1);
    test_wait_overrun();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
